spi_ram: RTL
============

# spi_ram

Single-port synchronous RAM that sits directly downstream of the SPI slave. Each 10-bit word received by the slave is consumed here: the top two bits select a command and the low byte carries the address or data. Read results are returned to the slave on `tx_data`/`tx_valid` for serialisation on MISO. Optional address auto-increment supports burst transfers.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, 8: address width in bits.
- `AUTO_INC`, 0: when 1, the write address increments after each write-data command and the read address after each read-data command.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 10: `[9:8]` command, `[7:0]` payload. Sampled only when `rx_valid`=1.
- `rx_valid` input 1: one-cycle qualifier from the SPI slave.
- `tx_data` output 8: read data returned to the SPI slave.
- `tx_valid` output 1: one-cycle pulse marking new `tx_data`.
- `cmd_err` output 1: one-cycle pulse when a data command arrives before its address has been loaded since reset.

## Operation
- Internal state:
  - `wr_addr`, `rd_addr`: each `ADDR_SIZE` bits.
  - `wr_addr_set`, `rd_addr_set`: 1-bit flags.
  - `mem`: `MEM_DEPTH` x 8 storage.
- Commands are decoded only on a rising edge with `rx_valid`=1.
- 00, write address:
  - `wr_addr` <= `rx_data[7:0]`; `wr_addr_set` <= 1.
- 01, write data:
  - If `wr_addr_set`=1: `mem[wr_addr]` <= `rx_data[7:0]`. If `AUTO_INC`=1, `wr_addr` <= `wr_addr`+1.
  - Else: memory is unchanged and `cmd_err` pulses.
- 10, read address:
  - `rd_addr` <= `rx_data[7:0]`; `rd_addr_set` <= 1.
  - Payload is otherwise ignored; no `tx_valid`.
- 11, read data:
  - If `rd_addr_set`=1: `tx_data` <= `mem[rd_addr]`; `tx_valid` pulses. If `AUTO_INC`=1, `rd_addr` <= `rd_addr`+1.
  - Else: `tx_data` holds, no `tx_valid`, `cmd_err` pulses.
  - The payload byte of a read-data command is a dummy and is ignored.
- Address arithmetic is modulo `MEM_DEPTH`: address 0xFF + 1 wraps to 0x00.
- When `rx_valid`=0 no state changes occur; `tx_valid` and `cmd_err` are 0.
- Single port: at most one memory access per cycle. `rx_valid` is at most one per cycle, so no arbitration is required.
- `wr_addr` and `rd_addr` are independent registers. A write to address A followed by a read from A returns the new data.

## Timing
- Reset (asynchronous assert, synchronous release by the system):
  - `tx_data`=0x00, `tx_valid`=0, `cmd_err`=0.
  - `wr_addr`=`rd_addr`=0; both `_set` flags = 0.
  - Memory contents are not reset and remain undefined until written.
- Write-data latency: memory is updated at the edge that samples the command; readable by a read-data command sampled one or more cycles later.
- Read-data latency: `tx_data`/`tx_valid` are registered and valid in the cycle after the edge that samples the command (1 cycle). `tx_valid` is high for exactly 1 cycle.
- `tx_data` holds its last value until the next successful read or reset.
- `cmd_err` is registered and is high for 1 cycle, in the cycle after the offending command.
- Back-to-back read-data commands on consecutive cycles (`AUTO_INC`=1) give consecutive `tx_valid` pulses with data from successive addresses.
- Reset asserted mid-burst:
  - Outputs clear immediately.
  - Both flags clear, so the next data command without a new address raises `cmd_err`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles mid-traffic -> `tx_data`=0, `tx_valid`=0, `cmd_err`=0 immediately, with no clock edge required.
- Write/read, `AUTO_INC`=0:
  - Stimulus: 0x0_3C, 0x1_A5, 0x2_3C, 0x3_00.
  - Response: `tx_data`=0xA5 with `tx_valid` high for 1 cycle, one cycle after the last command.
- Error path after reset:
  - Stimulus: 0x1_55 then 0x3_00.
  - Response: `cmd_err` pulses twice, no `tx_valid`, `tx_data` stays 0x00.
- Burst with wrap, `AUTO_INC`=1:
  - Stimulus: write address 0xFE, write data 0x11, 0x22, 0x33; then read address 0xFE and three read-data commands.
  - Response: `tx_data` sequence 0x11, 0x22, 0x33 (addresses 0xFE, 0xFF, 0x00).
- Idle stability: `rx_data` toggling randomly with `rx_valid`=0 for 50 cycles -> no change to memory, `tx_data`, `tx_valid`, or `cmd_err`.
- Independent pointers: set `wr_addr`=0x10 and `rd_addr`=0x20; write 0x77 -> read-data returns the prior content of 0x20, not 0x77.

Source files
------------

// File: rtl/spi_ram.sv
// Command-decoded single-port RAM behind the SPI slave: 10-bit words carry a
// 2-bit command and a byte payload; read results go back on tx_data/tx_valid.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_cmd_err
);

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;
  localparam logic       INC_EN    = (AUTO_INC != 0);

  logic [7:0]           r_mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wr_set;
  logic                 r_rd_set;

  logic [1:0]           w_cmd;
  logic [7:0]           w_pay;
  logic [ADDR_SIZE-1:0] w_addr;
  logic                 w_waddr;
  logic                 w_raddr;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic                 w_err;

  assign w_cmd   = i_rx_data[9:8];
  assign w_pay   = i_rx_data[7:0];
  assign w_addr  = w_pay[ADDR_SIZE-1:0];
  assign w_waddr = i_rx_valid && (w_cmd == CMD_WADDR);
  assign w_raddr = i_rx_valid && (w_cmd == CMD_RADDR);
  assign w_wr_ok = i_rx_valid && (w_cmd == CMD_WDATA) && r_wr_set;
  assign w_rd_ok = i_rx_valid && (w_cmd == CMD_RDATA) && r_rd_set;
  // Data command before its pointer was loaded since reset.
  assign w_err   = i_rx_valid && (((w_cmd == CMD_WDATA) && !r_wr_set) ||
                                  ((w_cmd == CMD_RDATA) && !r_rd_set));

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_addr] <= w_pay;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_wr_set   <= 1'b0;
      r_rd_set   <= 1'b0;
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_cmd_err  <= 1'b0;
    end else begin
      o_tx_valid <= w_rd_ok;
      o_cmd_err  <= w_err;
      if (w_waddr) begin
        r_wr_addr <= w_addr;
        r_wr_set  <= 1'b1;
      end else if (w_wr_ok && INC_EN) begin
        r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
      end
      if (w_raddr) begin
        r_rd_addr <= w_addr;
        r_rd_set  <= 1'b1;
      end else if (w_rd_ok) begin
        o_tx_data <= r_mem[r_rd_addr];
        if (INC_EN) r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
      end
    end
  end

endmodule
